// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes, datapath widths and the execute FSM state
// encoding. Used by decode, execute and writeback.
package cpu_pkg;

  localparam int unsigned OP_W     = 4;
  localparam int unsigned DATA_W   = 8;
  localparam int unsigned REG_AW   = 4;
  localparam int unsigned NUM_REGS = 16;
  localparam int unsigned REGS_W   = NUM_REGS * DATA_W;

  // Opcodes
  localparam logic [OP_W-1:0] OP_NOP  = 4'b0000;  // no operation
  localparam logic [OP_W-1:0] OP_LOD  = 4'b0001;  // rd <= mem[regs[rs]]
  localparam logic [OP_W-1:0] OP_STR  = 4'b0010;  // mem[regs[rs]] <= regs[rd]
  localparam logic [OP_W-1:0] OP_ADD  = 4'b0011;  // rd <= regs[rd] + regs[rs]
  localparam logic [OP_W-1:0] OP_ADDI = 4'b0100;  // rd <= regs[rd] + imm
  localparam logic [OP_W-1:0] OP_LODI = 4'b0101;  // rd <= imm
  localparam logic [OP_W-1:0] OP_NAND = 4'b0110;  // rd <= ~(regs[rd] & regs[rs])

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    EXEC = 3'd1,
    MEM  = 3'd2,
    WB   = 3'd3,
    DONE = 3'd4
  } state_t;

  // Select one register out of the flattened register-file bus.
  function automatic logic [DATA_W-1:0] reg_sel(input logic [REGS_W-1:0] r,
                                                input logic [REG_AW-1:0] idx);
    return r[32'(idx) * DATA_W +: DATA_W];
  endfunction

  // Opcodes that need a memory transaction before writeback.
  function automatic logic is_mem_op(input logic [OP_W-1:0] o);
    return (o == OP_LOD) || (o == OP_STR);
  endfunction

endpackage

// File: rtl/alu.sv
// Combinational result logic for the execute stage.
// Ports: op (opcode), a (regs[rd]), b (regs[rs]), imm (immediate),
//        result (8-bit, mod 256; memory and undefined ops yield 0).
module alu
  import cpu_pkg::*;
(
  input  logic [OP_W-1:0]   op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] imm,
  output logic [DATA_W-1:0] result
);

  // Carry out of the adders is intentionally dropped.
  always_comb begin
    result = '0;
    case (op)
      OP_ADD:  result = DATA_W'(a + b);
      OP_ADDI: result = DATA_W'(a + imm);
      OP_LODI: result = imm;
      OP_NAND: result = ~(a & b);
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/execute.sv
// Execute stage: latches one decoded instruction, computes its result,
// performs the memory handshake for LOD/STR, hands the result to writeback
// and pulses ready once writeback has accepted it.
// Ports:
//   clk, rst            - clock, asynchronous active-high reset
//   en, op, rd, rs, imm - decoded instruction (sampled only in IDLE)
//   regs                - flattened register file (16 x 8)
//   ready               - one-cycle retire pulse
//   mem_req/we/addr/wdata, mem_rdata/mem_ack - memory request handshake
//   wb_en/op/reg_addr/val, wb_ready           - writeback handshake
module execute
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [OP_W-1:0]   op,
  input  logic [REG_AW-1:0] rd,
  input  logic [REG_AW-1:0] rs,
  input  logic [DATA_W-1:0] imm,
  input  logic [REGS_W-1:0] regs,
  output logic              ready,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              wb_en,
  output logic [OP_W-1:0]   wb_op,
  output logic [REG_AW-1:0] wb_reg_addr,
  output logic [DATA_W-1:0] wb_val,
  input  logic              wb_ready
);

  state_t state_q, state_d;

  // Latched instruction
  logic [OP_W-1:0]   op_q, op_d;
  logic [REG_AW-1:0] rd_q, rd_d;
  logic [DATA_W-1:0] imm_q, imm_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;

  // Next values of the registered outputs
  logic              ready_d;
  logic              mem_req_d;
  logic              mem_we_d;
  logic [DATA_W-1:0] mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_d;
  logic              wb_en_d;
  logic [OP_W-1:0]   wb_op_d;
  logic [REG_AW-1:0] wb_reg_addr_d;
  logic [DATA_W-1:0] wb_val_d;

  logic [DATA_W-1:0] alu_result;

  alu u_alu (
    .op     (op_q),
    .a      (a_q),
    .b      (b_q),
    .imm    (imm_q),
    .result (alu_result)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state and next-output logic
  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    rd_d          = rd_q;
    imm_d         = imm_q;
    a_d           = a_q;
    b_d           = b_q;
    ready_d       = 1'b0;
    mem_req_d     = mem_req;
    mem_we_d      = mem_we;
    mem_addr_d    = mem_addr;
    mem_wdata_d   = mem_wdata;
    wb_en_d       = wb_en;
    wb_op_d       = wb_op;
    wb_reg_addr_d = wb_reg_addr;
    wb_val_d      = wb_val;

    case (state_q)
      IDLE: begin
        if (en) begin
          op_d    = op;
          rd_d    = rd;
          imm_d   = imm;
          a_d     = reg_sel(regs, rd);
          b_d     = reg_sel(regs, rs);
          state_d = EXEC;
        end
      end

      EXEC: begin
        wb_val_d      = alu_result;
        wb_op_d       = op_q;
        wb_reg_addr_d = rd_q;
        if (is_mem_op(op_q)) begin
          mem_req_d   = 1'b1;
          mem_we_d    = (op_q == OP_STR);
          mem_addr_d  = b_q;
          mem_wdata_d = a_q;
          state_d     = MEM;
        end else begin
          wb_en_d = 1'b1;
          state_d = WB;
        end
      end

      // mem_req drops on the same edge wb_en rises, so they never overlap.
      MEM: begin
        if (mem_ack) begin
          mem_req_d = 1'b0;
          if (!mem_we) wb_val_d = mem_rdata;
          wb_en_d   = 1'b1;
          state_d   = WB;
        end
      end

      WB: begin
        if (wb_ready) begin
          wb_en_d = 1'b0;
          ready_d = 1'b1;
          state_d = DONE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q        <= '0;
      rd_q        <= '0;
      imm_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      ready       <= 1'b0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      wb_en       <= 1'b0;
      wb_op       <= '0;
      wb_reg_addr <= '0;
      wb_val      <= '0;
    end else begin
      op_q        <= op_d;
      rd_q        <= rd_d;
      imm_q       <= imm_d;
      a_q         <= a_d;
      b_q         <= b_d;
      ready       <= ready_d;
      mem_req     <= mem_req_d;
      mem_we      <= mem_we_d;
      mem_addr    <= mem_addr_d;
      mem_wdata   <= mem_wdata_d;
      wb_en       <= wb_en_d;
      wb_op       <= wb_op_d;
      wb_reg_addr <= wb_reg_addr_d;
      wb_val      <= wb_val_d;
    end
  end

endmodule

// File: tb/tb_execute.sv
// Testbench for execute: directed and random instructions, memory and
// writeback responders with programmable latency, scoreboard monitor.
module tb_execute;
  import cpu_pkg::*;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en = 1'b0;
  logic [3:0]   op = '0;
  logic [3:0]   rd = '0;
  logic [3:0]   rs = '0;
  logic [7:0]   imm = '0;
  logic [127:0] regs = '0;
  logic         ready;
  logic         mem_req;
  logic         mem_we;
  logic [7:0]   mem_addr;
  logic [7:0]   mem_wdata;
  logic [7:0]   mem_rdata = '0;
  logic         mem_ack;
  logic         mem_ack_r = 1'b0;
  logic         mem_ack_g = 1'b0;
  logic         wb_en;
  logic [3:0]   wb_op;
  logic [3:0]   wb_reg_addr;
  logic [7:0]   wb_val;
  logic         wb_ready;
  logic         wb_ready_r = 1'b0;
  logic         wb_ready_g = 1'b0;

  assign mem_ack  = mem_ack_r | mem_ack_g;
  assign wb_ready = wb_ready_r | wb_ready_g;

  execute dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .op          (op),
    .rd          (rd),
    .rs          (rs),
    .imm         (imm),
    .regs        (regs),
    .ready       (ready),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_ack     (mem_ack),
    .wb_en       (wb_en),
    .wb_op       (wb_op),
    .wb_reg_addr (wb_reg_addr),
    .wb_val      (wb_val),
    .wb_ready    (wb_ready)
  );

  always #5 clk = ~clk;

  typedef struct { logic we; logic [7:0] addr; logic [7:0] wdata; int lat; } mem_exp_t;
  typedef struct { int lat; logic [7:0] rdata; } mem_rsp_t;
  typedef struct { logic [3:0] op; logic [3:0] rd; logic [7:0] val; bit chk_val; int lat; } wb_exp_t;

  mem_exp_t exp_mem_q[$];
  mem_rsp_t mem_rsp_q[$];
  wb_exp_t  exp_wb_q[$];
  int       wb_lat_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int retire_pending = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference result from the instruction-set definition, plain integer math.
  function automatic logic [7:0] model(input logic [3:0] o, input int a, input int b,
                                       input int im, input int rdata);
    int r;
    case (o)
      OP_LOD:  r = rdata;
      OP_ADD:  r = (a + b) % 256;
      OP_ADDI: r = (a + im) % 256;
      OP_LODI: r = im;
      OP_NAND: r = 255 - (a & b);
      default: r = 0;
    endcase
    return 8'(r);
  endfunction

  // Memory responder: ack on the lat-th cycle of mem_req.
  int       mcnt = 0;
  mem_rsp_t cur_rsp;
  always @(negedge clk) begin
    if (rst) begin
      mcnt = 0;
      mem_ack_r = 1'b0;
    end else if (mem_req) begin
      if (mcnt == 0) begin
        if (mem_rsp_q.size() > 0) cur_rsp = mem_rsp_q.pop_front();
        else cur_rsp = '{lat: 1, rdata: 8'h00};
      end
      mcnt++;
      mem_ack_r = (mcnt == cur_rsp.lat);
      mem_rdata = mem_ack_r ? cur_rsp.rdata : 8'($urandom);
    end else begin
      mcnt = 0;
      mem_ack_r = 1'b0;
      mem_rdata = 8'($urandom);
    end
  end

  // Writeback responder: ready on the lat-th cycle of wb_en.
  int wcnt = 0;
  int cur_wlat = 2;
  always @(negedge clk) begin
    if (rst) begin
      wcnt = 0;
      wb_ready_r = 1'b0;
    end else if (wb_en) begin
      if (wcnt == 0) begin
        if (wb_lat_q.size() > 0) cur_wlat = wb_lat_q.pop_front();
        else cur_wlat = 2;
      end
      wcnt++;
      wb_ready_r = (wcnt == cur_wlat);
    end else begin
      wcnt = 0;
      wb_ready_r = 1'b0;
    end
  end

  // Scoreboard monitor
  int       mem_cyc = 0;
  int       wb_cyc = 0;
  mem_exp_t cur_mem;
  wb_exp_t  cur_wb;
  logic     prev_ready = 1'b0;
  bit       have;
  always @(negedge clk) begin
    if (rst) begin
      mem_cyc = 0;
      wb_cyc = 0;
      retire_pending = 0;
      prev_ready = 1'b0;
    end else begin
      if (mem_req || wb_en) check("mem_wb_exclusive", 32'(mem_req && wb_en), 32'(0));
      if (mem_req) begin
        if (mem_cyc == 0) begin
          have = exp_mem_q.size() > 0;
          check("mem_expected", 32'(have), 32'(1));
          if (have) cur_mem = exp_mem_q.pop_front();
          else cur_mem = '{we: 1'b0, addr: 8'h00, wdata: 8'h00, lat: -1};
        end
        mem_cyc++;
        check("mem_addr", 32'(mem_addr), 32'(cur_mem.addr));
        check("mem_we", 32'(mem_we), 32'(cur_mem.we));
        if (cur_mem.we) check("mem_wdata", 32'(mem_wdata), 32'(cur_mem.wdata));
      end else if (mem_cyc != 0) begin
        check("mem_req_cycles", 32'(mem_cyc), 32'(cur_mem.lat));
        mem_cyc = 0;
      end
      if (wb_en) begin
        if (wb_cyc == 0) begin
          have = exp_wb_q.size() > 0;
          check("wb_expected", 32'(have), 32'(1));
          if (have) cur_wb = exp_wb_q.pop_front();
          else cur_wb = '{op: 4'h0, rd: 4'h0, val: 8'h00, chk_val: 1'b0, lat: -1};
        end
        wb_cyc++;
        check("wb_op", 32'(wb_op), 32'(cur_wb.op));
        check("wb_reg_addr", 32'(wb_reg_addr), 32'(cur_wb.rd));
        if (cur_wb.chk_val) check("wb_val", 32'(wb_val), 32'(cur_wb.val));
      end else if (wb_cyc != 0) begin
        check("wb_en_cycles", 32'(wb_cyc), 32'(cur_wb.lat));
        wb_cyc = 0;
        retire_pending++;
      end
      if (ready) begin
        check("ready_after_wb", 32'(retire_pending), 32'(1));
        check("ready_single", 32'(prev_ready), 32'(0));
        retire_pending = 0;
      end
      prev_ready = ready;
    end
  end

  task automatic flush_queues();
    exp_mem_q.delete();
    mem_rsp_q.delete();
    exp_wb_q.delete();
    wb_lat_q.delete();
  endtask

  task automatic recover();
    rst = 1'b1;
    en  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    flush_queues();
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Issue one instruction and wait for its retire pulse. Called right after a negedge.
  task automatic run_instr(input logic [3:0] o, input logic [3:0] d, input logic [3:0] s,
                           input logic [7:0] a_val, input logic [7:0] b_val,
                           input logic [7:0] im, input int mlat, input logic [7:0] rdat,
                           input int wlat, input bit glitch_en);
    logic [7:0] rm [16];
    int a, b, cnt, exp_lat;
    bit is_mem;
    for (int i = 0; i < 16; i++) rm[i] = 8'($urandom);
    rm[d] = a_val;
    rm[s] = b_val;
    a = int'(rm[d]);
    b = int'(rm[s]);
    for (int i = 0; i < 16; i++) regs[i*8 +: 8] = rm[i];
    is_mem = (o == OP_LOD) || (o == OP_STR);
    if (is_mem) begin
      exp_mem_q.push_back('{we: (o == OP_STR), addr: 8'(b), wdata: 8'(a), lat: mlat});
      mem_rsp_q.push_back('{lat: mlat, rdata: rdat});
    end
    exp_wb_q.push_back('{op: o, rd: d, val: model(o, a, b, int'(im), int'(rdat)),
                         chk_val: (o != OP_STR), lat: wlat});
    wb_lat_q.push_back(wlat);
    exp_lat = wlat + 2 + (is_mem ? mlat : 0);

    en = 1'b1; op = o; rd = d; rs = s; imm = im;
    @(negedge clk);
    cnt = 1;
    // Inputs change after the sample: the instruction must already be latched.
    en = 1'b0;
    op = glitch_en ? OP_LODI : 4'($urandom);
    rd = 4'($urandom); rs = 4'($urandom); imm = 8'($urandom);
    regs = {4{$urandom}};
    while (!ready && cnt < 200) begin
      @(negedge clk);
      cnt++;
      if (glitch_en) en = (cnt == 2) || (cnt == 3);
    end
    en = 1'b0;
    check("ready_seen", 32'(ready), 32'(1));
    if (ready) begin
      check("latency", 32'(cnt), 32'(exp_lat));
      @(negedge clk);
      check("ready_dropped", 32'(ready), 32'(0));
    end else begin
      recover();
    end
  endtask

  // Handshake pulses while idle must not start anything.
  task automatic idle_glitch();
    mem_ack_g = 1'b1;
    wb_ready_g = 1'b1;
    @(negedge clk);
    @(negedge clk);
    mem_ack_g = 1'b0;
    wb_ready_g = 1'b0;
    @(negedge clk);
    check("idle_glitch_mem_req", 32'(mem_req), 32'(0));
    check("idle_glitch_wb_en", 32'(wb_en), 32'(0));
    check("idle_glitch_ready", 32'(ready), 32'(0));
  endtask

  // Reset in the middle of a long memory wait abandons the instruction.
  task automatic reset_mid_mem();
    int cnt;
    regs = {4{$urandom}};
    regs[6*8 +: 8] = 8'h33;
    exp_mem_q.push_back('{we: 1'b0, addr: 8'h33, wdata: 8'h00, lat: 50});
    mem_rsp_q.push_back('{lat: 50, rdata: 8'h77});
    en = 1'b1; op = OP_LOD; rd = 4'd2; rs = 4'd6; imm = 8'h00;
    @(negedge clk);
    en = 1'b0;
    cnt = 0;
    while (!mem_req && cnt < 10) begin
      @(negedge clk);
      cnt++;
    end
    check("rst_mem_req_seen", 32'(mem_req), 32'(1));
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_async_mem_req", 32'(mem_req), 32'(0));
    check("rst_async_wb_en", 32'(wb_en), 32'(0));
    check("rst_async_ready", 32'(ready), 32'(0));
    check("rst_async_mem_addr", 32'(mem_addr), 32'(0));
    @(negedge clk);
    @(negedge clk);
    flush_queues();
    rst = 1'b0;
    repeat (6) begin
      @(negedge clk);
      check("post_rst_mem_req", 32'(mem_req), 32'(0));
      check("post_rst_wb_en", 32'(wb_en), 32'(0));
      check("post_rst_ready", 32'(ready), 32'(0));
    end
  endtask

  initial begin
    logic [3:0] o;
    bit g;
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(ready), 32'(0));
    check("rst_mem_req", 32'(mem_req), 32'(0));
    check("rst_mem_we", 32'(mem_we), 32'(0));
    check("rst_mem_addr", 32'(mem_addr), 32'(0));
    check("rst_mem_wdata", 32'(mem_wdata), 32'(0));
    check("rst_wb_en", 32'(wb_en), 32'(0));
    check("rst_wb_op", 32'(wb_op), 32'(0));
    check("rst_wb_reg_addr", 32'(wb_reg_addr), 32'(0));
    check("rst_wb_val", 32'(wb_val), 32'(0));
    rst = 1'b0;
    @(negedge clk);

    // Directed cases
    run_instr(OP_ADD,  4'd1, 4'd2, 8'h7F, 8'h81, 8'h00, 0, 8'h00, 2, 1'b0);
    run_instr(OP_NAND, 4'd3, 4'd4, 8'hF0, 8'hCC, 8'h00, 0, 8'h00, 2, 1'b0);
    run_instr(OP_ADDI, 4'd5, 4'd0, 8'hFF, 8'h00, 8'h02, 0, 8'h00, 3, 1'b0);
    run_instr(OP_LOD,  4'd9, 4'd6, 8'h00, 8'h20, 8'h00, 3, 8'hA5, 2, 1'b0);
    run_instr(OP_STR,  4'd7, 4'd8, 8'h5A, 8'h10, 8'h00, 1, 8'h00, 2, 1'b0);
    run_instr(OP_LOD,  4'd0, 4'd1, 8'h00, 8'hFE, 8'h00, 1, 8'h3C, 2, 1'b0);
    run_instr(OP_LODI, 4'd4, 4'd4, 8'h00, 8'h00, 8'hC3, 0, 8'h00, 2, 1'b1);
    run_instr(OP_NOP,  4'd2, 4'd3, 8'h11, 8'h22, 8'h33, 0, 8'h00, 2, 1'b0);
    run_instr(4'hF,    4'd6, 4'd7, 8'h44, 8'h55, 8'h66, 0, 8'h00, 2, 1'b0);
    idle_glitch();
    reset_mid_mem();
    run_instr(OP_ADD,  4'd15, 4'd15, 8'h80, 8'h80, 8'h00, 0, 8'h00, 2, 1'b0);

    // Random instructions
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 3) == 0) o = 4'($urandom_range(7, 15));
      else o = 4'($urandom_range(0, 6));
      g = (o != OP_LOD) && (o != OP_STR) && ($urandom_range(0, 3) == 0);
      run_instr(o, 4'($urandom), 4'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                int'($urandom_range(1, 4)), 8'($urandom), int'($urandom_range(2, 4)), g);
      if ($urandom_range(0, 7) == 0) idle_glitch();
    end

    repeat (3) @(negedge clk);
    check("end_wb_queue_empty", 32'(exp_wb_q.size()), 32'(0));
    check("end_mem_queue_empty", 32'(exp_mem_q.size()), 32'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/execute.md
EXECUTE -- requirements
Module: execute

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- OP_NOP, 4'b0000, no operation
- OP_LOD, 4'b0001, rd <= mem[regs[rs]]
- OP_STR, 4'b0010, mem[regs[rs]] <= regs[rd]
- OP_ADD, 4'b0011, rd <= regs[rd] + regs[rs]
- OP_ADDI, 4'b0100, rd <= regs[rd] + imm
- OP_LODI, 4'b0101, rd <= imm
- OP_NAND, 4'b0110, rd <= ~(regs[rd] & regs[rs])
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1, sole clock, rising edge
- rst, in, 1, asynchronous, active-high reset
- en, in, 1, decoded instruction valid
- op, in, 4, opcode
- rd, in, 4, destination / first source register
- rs, in, 4, second source / address register
- imm, in, 8, immediate
- regs, in, 8x16, register file contents from writeback
- ready, out, 1, one-cycle retire pulse; next instruction may be presented
- mem_req, out, 1, memory request
- mem_we, out, 1, 1 = store, 0 = load
- mem_addr, out, 8, memory address
- mem_wdata, out, 8, store data
- mem_rdata, in, 8, load data, valid with mem_ack
- mem_ack, in, 1, memory request complete
- wb_en, out, 1, writeback enable
- wb_op, out, 4, opcode forwarded to writeback
- wb_reg_addr, out, 4, destination register forwarded
- wb_val, out, 8, result forwarded
- wb_ready, in, 1, writeback complete
REQ-003 Reset SHALL be asynchronous and active-high on rst; clock SHALL be clk only.

Function
REQ-004 The FSM SHALL have states IDLE, EXEC, MEM, WB, DONE.
REQ-005 IDLE with en=1 SHALL latch op, rd, rs, imm, regs[rd] and regs[rs] and enter EXEC; en is ignored in every other state.
REQ-006 EXEC SHALL compute the result into a registered wb_val, with all arithmetic mod 256 and carry discarded; LOD/STR go to MEM, all others go to WB.
REQ-007 In MEM, mem_req SHALL be held high with stable mem_addr=regs[rs], mem_we and mem_wdata=regs[rd] until mem_ack=1 is sampled; that edge SHALL drop mem_req, capture mem_rdata into wb_val for LOD, and enter WB.
REQ-008 In WB, wb_en SHALL be held high with stable wb_op, wb_reg_addr and wb_val until wb_ready=1 is sampled; that edge SHALL drop wb_en and enter DONE.
REQ-009 Every opcode, including STR, NOP and undefined ones, SHALL pass through WB so that writeback signals retirement; undefined opcodes behave as NOP with wb_val=0.
REQ-010 DONE SHALL assert ready for exactly one cycle, then return to IDLE.
REQ-011 Minimum latency for non-memory ops, from the en sample to the ready pulse, SHALL be: EXEC (1 cycle) + WB (≥2 cycles, since writeback requires en on two consecutive edges) + DONE (1 cycle).
REQ-012 A mem_ack arriving outside MEM and a wb_ready arriving outside WB SHALL be ignored.
REQ-013 A mem_ack sampled on the first MEM cycle SHALL be accepted, giving a single-cycle MEM.
REQ-014 mem_req and wb_en SHALL never be high in the same cycle.

Reset
REQ-015 Reset SHALL force state to IDLE and set ready, mem_req, mem_we, wb_en to 0 and mem_addr, mem_wdata, wb_op, wb_reg_addr, wb_val to 0.
REQ-016 Reset in any state SHALL abandon the in-flight instruction; no request or enable is reasserted after reset is released.

Structure
REQ-017 Opcode constants and the FSM state encoding SHALL live in a shared package cpu_pkg, used by this block, writeback and decode.
REQ-018 Combinational result logic SHALL be one sub-module, alu (inputs op, a, b, imm; output 8-bit result).

Verification
REQ-019 ADD with regs[1]=0x7F, regs[2]=0x81, rd=1, rs=2, wb_ready returned after 2 wb_en cycles -> wb_val=0x00, wb_reg_addr=1, then a single ready pulse.
REQ-020 NAND with regs[3]=0xF0, regs[4]=0xCC -> wb_val=0x3F; ADDI with regs[5]=0xFF, imm=0x02 -> wb_val=0x01.
REQ-021 LOD with regs[6]=0x20, mem_ack after 3 cycles with mem_rdata=0xA5 -> mem_addr=0x20, mem_we=0, mem_req held 3 cycles, then wb_val=0xA5.
REQ-022 STR with regs[7]=0x5A, regs[8]=0x10 -> mem_we=1, mem_addr=0x10, mem_wdata=0x5A; then WB with wb_op=OP_STR, then ready.
REQ-023 en pulsed during WB, and wb_ready and mem_ack pulsed in IDLE -> no state change and no second instruction.
REQ-024 rst asserted mid-MEM -> mem_req=0 immediately (asynchronous), state IDLE, no wb_en or ready afterwards.
